// File: rtl/turf_generic_axil_bridge_if.sv
// Signal bundle around turf_generic_axil_bridge: TURF generic register port plus AXI4-Lite port.
// The slave modport is the bridge's view; the master modport is the surrounding system's view.
interface turf_generic_axil_bridge_if;
  logic        s_en_i;
  logic        s_wr_i;
  logic        s_ack_o;
  logic [27:0] s_adr_i;
  logic [31:0] s_dat_i;
  logic [31:0] s_dat_o;

  logic [29:0] m_axil_awaddr;
  logic        m_axil_awvalid;
  logic        m_axil_awready;
  logic [31:0] m_axil_wdata;
  logic [3:0]  m_axil_wstrb;
  logic        m_axil_wvalid;
  logic        m_axil_wready;
  logic [1:0]  m_axil_bresp;
  logic        m_axil_bvalid;
  logic        m_axil_bready;
  logic [29:0] m_axil_araddr;
  logic        m_axil_arvalid;
  logic        m_axil_arready;
  logic [31:0] m_axil_rdata;
  logic [1:0]  m_axil_rresp;
  logic        m_axil_rvalid;
  logic        m_axil_rready;

  modport master (
    output s_en_i, s_wr_i, s_adr_i, s_dat_i,
    input  s_ack_o, s_dat_o,
    input  m_axil_awaddr, m_axil_awvalid, m_axil_wdata, m_axil_wstrb, m_axil_wvalid,
    input  m_axil_bready, m_axil_araddr, m_axil_arvalid, m_axil_rready,
    output m_axil_awready, m_axil_wready, m_axil_bresp, m_axil_bvalid,
    output m_axil_arready, m_axil_rdata, m_axil_rresp, m_axil_rvalid
  );

  modport slave (
    input  s_en_i, s_wr_i, s_adr_i, s_dat_i,
    output s_ack_o, s_dat_o,
    output m_axil_awaddr, m_axil_awvalid, m_axil_wdata, m_axil_wstrb, m_axil_wvalid,
    output m_axil_bready, m_axil_araddr, m_axil_arvalid, m_axil_rready,
    input  m_axil_awready, m_axil_wready, m_axil_bresp, m_axil_bvalid,
    input  m_axil_arready, m_axil_rdata, m_axil_rresp, m_axil_rvalid
  );
endinterface

// File: rtl/turf_generic_axil_bridge.sv
// Single-outstanding bridge from the TURF generic register port to an AXI4-Lite master.
// A per-transaction timeout forces an erroring ack if the AXI slave never answers.
module turf_generic_axil_bridge #(
  parameter int unsigned TIMEOUT  = 1024,
  parameter logic [31:0] ERR_DATA = 32'hBAADF00D
) (
  input  logic                     clk,
  input  logic                     rst_n,
  turf_generic_axil_bridge_if.slave bus,
  output logic                     err_o,
  output logic                     timeout_o
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WADDR = 3'd1;
  localparam logic [2:0] WRESP = 3'd2;
  localparam logic [2:0] RADDR = 3'd3;
  localparam logic [2:0] RDATA = 3'd4;
  localparam logic [2:0] ACK   = 3'd5;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  logic [2:0]  state;
  logic [15:0] cnt;
  logic [27:0] adr_q;
  logic [31:0] dat_q;
  logic        aw_done;
  logic        w_done;

  logic expired;
  logic aw_hs;
  logic w_hs;
  logic aw_fin;
  logic w_fin;

  assign expired = (cnt == CNT_LAST);
  assign aw_hs   = bus.m_axil_awvalid & bus.m_axil_awready;
  assign w_hs    = bus.m_axil_wvalid & bus.m_axil_wready;
  assign aw_fin  = aw_done | aw_hs;
  assign w_fin   = w_done | w_hs;

  assign bus.m_axil_awaddr = {adr_q, 2'b00};
  assign bus.m_axil_araddr = {adr_q, 2'b00};
  assign bus.m_axil_wdata  = dat_q;
  assign bus.m_axil_wstrb  = 4'hF;

  // Saturates at CNT_LAST so a phase entered on the expiry cycle still times out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == IDLE) begin
      cnt <= '0;
    end else if (state != ACK && !expired) begin
      cnt <= cnt + 16'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; later assignments in the block override earlier ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      adr_q              <= '0;
      dat_q              <= '0;
      aw_done            <= 1'b0;
      w_done             <= 1'b0;
      bus.m_axil_awvalid <= 1'b0;
      bus.m_axil_wvalid  <= 1'b0;
      bus.m_axil_bready  <= 1'b0;
      bus.m_axil_arvalid <= 1'b0;
      bus.m_axil_rready  <= 1'b0;
      bus.s_ack_o        <= 1'b0;
      bus.s_dat_o        <= '0;
      err_o              <= 1'b0;
      timeout_o          <= 1'b0;
    end else begin
      bus.s_ack_o <= 1'b0;
      err_o       <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.s_en_i) begin
            adr_q   <= bus.s_adr_i;
            dat_q   <= bus.s_dat_i;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            if (bus.s_wr_i) begin
              state              <= WADDR;
              bus.m_axil_awvalid <= 1'b1;
              bus.m_axil_wvalid  <= 1'b1;
            end else begin
              state              <= RADDR;
              bus.m_axil_arvalid <= 1'b1;
            end
          end
        end
        WADDR: begin
          if (aw_hs) begin
            bus.m_axil_awvalid <= 1'b0;
            aw_done            <= 1'b1;
          end
          if (w_hs) begin
            bus.m_axil_wvalid <= 1'b0;
            w_done            <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            state             <= WRESP;
            bus.m_axil_bready <= 1'b1;
          end else if (expired) begin
            bus.m_axil_awvalid <= 1'b0;
            bus.m_axil_wvalid  <= 1'b0;
            err_o              <= 1'b1;
            timeout_o          <= 1'b1;
            bus.s_ack_o        <= 1'b1;
            state              <= ACK;
          end
        end
        WRESP: begin
          if (bus.m_axil_bvalid) begin
            bus.m_axil_bready <= 1'b0;
            err_o             <= (bus.m_axil_bresp != 2'b00);
            bus.s_ack_o       <= 1'b1;
            state             <= ACK;
          end else if (expired) begin
            bus.m_axil_bready <= 1'b0;
            err_o             <= 1'b1;
            timeout_o         <= 1'b1;
            bus.s_ack_o       <= 1'b1;
            state             <= ACK;
          end
        end
        RADDR: begin
          if (bus.m_axil_arready) begin
            bus.m_axil_arvalid <= 1'b0;
            bus.m_axil_rready  <= 1'b1;
            state              <= RDATA;
          end else if (expired) begin
            bus.m_axil_arvalid <= 1'b0;
            bus.s_dat_o        <= ERR_DATA;
            err_o              <= 1'b1;
            timeout_o          <= 1'b1;
            bus.s_ack_o        <= 1'b1;
            state              <= ACK;
          end
        end
        RDATA: begin
          if (bus.m_axil_rvalid) begin
            bus.m_axil_rready <= 1'b0;
            bus.s_dat_o       <= (bus.m_axil_rresp == 2'b00) ? bus.m_axil_rdata : ERR_DATA;
            err_o             <= (bus.m_axil_rresp != 2'b00);
            bus.s_ack_o       <= 1'b1;
            state             <= ACK;
          end else if (expired) begin
            bus.m_axil_rready <= 1'b0;
            bus.s_dat_o       <= ERR_DATA;
            err_o             <= 1'b1;
            timeout_o         <= 1'b1;
            bus.s_ack_o       <= 1'b1;
            state             <= ACK;
          end
        end
        // The request may still be held here; IDLE samples it next cycle.
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_turf_generic_axil_bridge.sv
// Self-checking bench for turf_generic_axil_bridge: directed corner cases plus randomized
// transactions against a latency/response model driven by a delay-configurable AXI slave.
module tb_turf_generic_axil_bridge;
  localparam int          TO       = 16;
  localparam int          NEVER    = 1000;
  localparam logic [31:0] ERR_DATA = 32'hBAADF00D;

  logic clk = 1'b0;
  logic rst_n;
  logic err_o;
  logic timeout_o;

  int checks = 0;
  int errors = 0;

  int          cfg_da = 0;
  int          cfg_dw = 0;
  int          cfg_dr = 0;
  logic [1:0]  cfg_resp = 2'b00;
  logic [31:0] cfg_rdata = '0;

  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
  int aw_hi = 0, w_hi = 0, ar_hi = 0, rdy_hi = 0;
  int aw_hs = 0, w_hs = 0, ar_hs = 0;
  logic [29:0] cap_awaddr = '0;
  logic [29:0] cap_araddr = '0;
  logic [31:0] cap_wdata = '0;
  logic [3:0]  cap_wstrb = '0;

  logic [31:0] exp_dat = '0;
  logic        exp_timeout = 1'b0;

  turf_generic_axil_bridge_if bus ();

  turf_generic_axil_bridge #(
    .TIMEOUT  (TO),
    .ERR_DATA (ERR_DATA)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .err_o     (err_o),
    .timeout_o (timeout_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // AXI slave: each ready/valid answers after the configured number of waiting cycles.
  initial begin
    bus.m_axil_awready = 1'b0;
    bus.m_axil_wready  = 1'b0;
    bus.m_axil_arready = 1'b0;
    bus.m_axil_bvalid  = 1'b0;
    bus.m_axil_bresp   = 2'b00;
    bus.m_axil_rvalid  = 1'b0;
    bus.m_axil_rresp   = 2'b00;
    bus.m_axil_rdata   = '0;
    forever begin
      @(negedge clk);
      bus.m_axil_awready = bus.m_axil_awvalid && (aw_cnt == cfg_da);
      if (bus.m_axil_awready) begin aw_hs++; cap_awaddr = bus.m_axil_awaddr; end
      if (bus.m_axil_awvalid) begin aw_cnt++; aw_hi++; end else aw_cnt = 0;

      bus.m_axil_wready = bus.m_axil_wvalid && (w_cnt == cfg_dw);
      if (bus.m_axil_wready) begin
        w_hs++;
        cap_wdata = bus.m_axil_wdata;
        cap_wstrb = bus.m_axil_wstrb;
      end
      if (bus.m_axil_wvalid) begin w_cnt++; w_hi++; end else w_cnt = 0;

      bus.m_axil_arready = bus.m_axil_arvalid && (ar_cnt == cfg_da);
      if (bus.m_axil_arready) begin ar_hs++; cap_araddr = bus.m_axil_araddr; end
      if (bus.m_axil_arvalid) begin ar_cnt++; ar_hi++; end else ar_cnt = 0;

      bus.m_axil_bvalid = bus.m_axil_bready && (b_cnt == cfg_dr);
      bus.m_axil_bresp  = cfg_resp;
      if (bus.m_axil_bready) begin b_cnt++; rdy_hi++; end else b_cnt = 0;

      bus.m_axil_rvalid = bus.m_axil_rready && (r_cnt == cfg_dr);
      bus.m_axil_rresp  = cfg_resp;
      bus.m_axil_rdata  = cfg_rdata;
      if (bus.m_axil_rready) begin r_cnt++; rdy_hi++; end else r_cnt = 0;
    end
  end

  // One request from the generic side; expectations come from the delay arithmetic:
  // ack = 3 + address-phase wait + response wait, capped at TO+1 with a timeout.
  task automatic run_txn(input string tag, input logic wr, input logic [27:0] adr,
                         input logic [31:0] dat, input int da, input int dw, input int dr,
                         input logic [1:0] resp, input logic [31:0] rdata);
    int   phase1, normal, exp_lat, got;
    logic to, exp_err, p1_done;
    phase1  = (wr && dw > da) ? dw : da;
    normal  = 3 + phase1 + dr;
    to      = (normal > TO + 1);
    exp_lat = to ? TO + 1 : normal;
    exp_err = to || (resp != 2'b00);
    p1_done = (phase1 + 1 <= TO);
    if (!wr) exp_dat = (to || resp != 2'b00) ? ERR_DATA : rdata;
    exp_timeout = exp_timeout | to;

    cfg_da = da; cfg_dw = dw; cfg_dr = dr; cfg_resp = resp; cfg_rdata = rdata;
    aw_hi = 0; w_hi = 0; ar_hi = 0; rdy_hi = 0; aw_hs = 0; w_hs = 0; ar_hs = 0;
    cap_awaddr = '0; cap_araddr = '0; cap_wdata = '0; cap_wstrb = '0;

    bus.s_en_i  = 1'b1;
    bus.s_wr_i  = wr;
    bus.s_adr_i = adr;
    bus.s_dat_i = dat;
    @(posedge clk);
    got = -1;
    for (int cyc = 1; cyc <= TO + 8; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        bus.s_adr_i = 28'($urandom);
        bus.s_dat_i = $urandom;
        bus.s_wr_i  = ~wr;
      end
      if (bus.s_ack_o) begin
        got = cyc;
        break;
      end
    end
    bus.s_en_i = 1'b0;

    check({tag, "/ack_cycle"}, got, exp_lat);
    check({tag, "/err"}, err_o, exp_err);
    check({tag, "/s_dat_o"}, bus.s_dat_o, exp_dat);
    check({tag, "/timeout_o"}, timeout_o, exp_timeout);
    check({tag, "/axi_idle"}, {bus.m_axil_awvalid, bus.m_axil_wvalid, bus.m_axil_arvalid,
                               bus.m_axil_bready, bus.m_axil_rready}, 5'b0);
    if (wr) begin
      check({tag, "/aw_hs"}, aw_hs, (da + 1 <= TO) ? 1 : 0);
      check({tag, "/w_hs"}, w_hs, (dw + 1 <= TO) ? 1 : 0);
      check({tag, "/aw_valid_cycles"}, aw_hi, (da + 1 < TO) ? da + 1 : TO);
      check({tag, "/w_valid_cycles"}, w_hi, (dw + 1 < TO) ? dw + 1 : TO);
      if (da + 1 <= TO) check({tag, "/awaddr"}, cap_awaddr, {adr, 2'b00});
      if (dw + 1 <= TO) begin
        check({tag, "/wdata"}, cap_wdata, dat);
        check({tag, "/wstrb"}, cap_wstrb, 4'hF);
      end
    end else begin
      check({tag, "/ar_hs"}, ar_hs, (da + 1 <= TO) ? 1 : 0);
      check({tag, "/ar_valid_cycles"}, ar_hi, (da + 1 < TO) ? da + 1 : TO);
      if (da + 1 <= TO) check({tag, "/araddr"}, cap_araddr, {adr, 2'b00});
    end
    check({tag, "/resp_ready_cycles"}, rdy_hi, p1_done ? exp_lat - 2 - phase1 : 0);

    @(negedge clk);
    check({tag, "/ack_one_cycle"}, bus.s_ack_o, 1'b0);
    check({tag, "/err_one_cycle"}, err_o, 1'b0);
    check({tag, "/s_dat_o_held"}, bus.s_dat_o, exp_dat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ack1, ack2;
    rst_n       = 1'b0;
    bus.s_en_i  = 1'b0;
    bus.s_wr_i  = 1'b0;
    bus.s_adr_i = '0;
    bus.s_dat_i = '0;
    repeat (3) @(negedge clk);
    check("reset/outputs", {bus.s_ack_o, err_o, timeout_o, bus.m_axil_awvalid, bus.m_axil_wvalid,
                            bus.m_axil_arvalid, bus.m_axil_bready, bus.m_axil_rready}, 8'b0);
    check("reset/s_dat_o", bus.s_dat_o, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn("wr_zero_wait", 1'b1, 28'h0000123, 32'hCAFEF00D, 0, 0, 0, 2'b00, 32'h0);
    run_txn("rd_rvalid_late", 1'b0, 28'h0ABCDE0, 32'h0, 0, 0, 5, 2'b00, 32'h12345678);
    run_txn("wr_w_first_slverr", 1'b1, 28'h7654321, 32'h0BADCAFE, 3, 0, 0, 2'b10, 32'h0);
    run_txn("rd_decerr", 1'b0, 28'h0000042, 32'h0, 1, 0, 2, 2'b11, 32'h55AA55AA);
    run_txn("rd_no_arready", 1'b0, 28'h0000777, 32'h0, NEVER, 0, 0, 2'b00, 32'h0);
    run_txn("rd_rvalid_at_expiry", 1'b0, 28'h0001000, 32'h0, 0, 0, TO - 2, 2'b00, 32'hA5A5F00F);
    run_txn("rd_rvalid_after_expiry", 1'b0, 28'h0001004, 32'h0, 0, 0, TO - 1, 2'b00, 32'h11112222);
    run_txn("wr_no_bvalid", 1'b1, 28'h0002000, 32'hDEADBEEF, 0, 2, NEVER, 2'b00, 32'h0);
    run_txn("wr_no_awready", 1'b1, 28'h0002004, 32'h01234567, NEVER, 1, 0, 2'b00, 32'h0);

    for (int i = 0; i < 10; i++) begin
      logic [1:0] resp;
      resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      run_txn("random", 1'($urandom_range(0, 1)), 28'($urandom), $urandom,
              $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4), resp, $urandom);
    end

    // Request held through the ack and two more cycles: exactly two writes, 4 cycles apart.
    cfg_da = 0; cfg_dw = 0; cfg_dr = 0; cfg_resp = 2'b00;
    aw_hs = 0;
    ack1 = -1;
    ack2 = -1;
    bus.s_en_i  = 1'b1;
    bus.s_wr_i  = 1'b1;
    bus.s_adr_i = 28'($urandom);
    bus.s_dat_i = $urandom;
    @(posedge clk);
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (cyc == 5) bus.s_en_i = 1'b0;
      if (bus.s_ack_o) begin
        if (ack1 < 0) ack1 = cyc;
        else if (ack2 < 0) ack2 = cyc;
      end
    end
    check("b2b/aw_count", aw_hs, 2);
    check("b2b/first_ack", ack1, 3);
    check("b2b/second_ack", ack2, 7);

    // Reset in the middle of the write-response wait.
    cfg_da = 0; cfg_dw = 0; cfg_dr = NEVER;
    bus.s_en_i  = 1'b1;
    bus.s_wr_i  = 1'b1;
    bus.s_adr_i = 28'($urandom_range(1, 28'hFFFFFFF));
    bus.s_dat_i = $urandom_range(1, 32'hFFFFFFF);
    @(posedge clk);
    repeat (3) @(negedge clk);
    check("mid_wresp/bready", bus.m_axil_bready, 1'b1);
    check("mid_wresp/timeout_sticky", timeout_o, exp_timeout);
    bus.s_en_i = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_wresp_reset/outputs", {bus.s_ack_o, err_o, timeout_o, bus.m_axil_awvalid,
                                      bus.m_axil_wvalid, bus.m_axil_arvalid, bus.m_axil_bready,
                                      bus.m_axil_rready}, 8'b0);
    check("mid_wresp_reset/s_dat_o", bus.s_dat_o, 32'h0);
    check("mid_wresp_reset/addr_data", {bus.m_axil_awaddr, bus.m_axil_wdata}, 62'h0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_dat = '0;
    exp_timeout = 1'b0;
    @(negedge clk);
    run_txn("post_reset_read", 1'b0, 28'($urandom), 32'h0, 0, 0, 0, 2'b00, $urandom);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
